fifo_push_arbiter: RTL and testbench
====================================

# fifo_push_arbiter

Round-robin arbiter that shares the push side of one `fifo` instance between `NUM_REQ` producers. Each producer uses the same valid/grant handshake as the FIFO push port. The arbiter forwards exactly one producer's valid/data per cycle and routes the FIFO's grant back to that producer only. It sits directly in front of `fifo`, with `fifo_valid_o`/`fifo_data_o`/`fifo_grant_i` wired to `push_valid_i`/`push_data_i`/`push_grant_o`.

## Interface
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 8: payload width; must match the FIFO.
- `MAX_BURST`, 4: maximum consecutive beats per owner in burst mode, ≥1.
- `IDX_W`: local, `$clog2(NUM_REQ)`.

Ports (clock and reset first):
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid_i` in NUM_REQ: per-producer valid.
- `req_data_i` in NUM_REQ*DATA_WIDTH: producer k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- `req_grant_o` out NUM_REQ: per-producer grant; at most one bit set.
- `fifo_valid_o` out 1: to FIFO `push_valid_i`.
- `fifo_data_o` out DATA_WIDTH: to FIFO `push_data_i`.
- `fifo_grant_i` in 1: from FIFO `push_grant_o`.
- `owner_o` out IDX_W: currently selected producer (debug/observability).

## Operation
- **Transfer:** a beat transfers in any cycle with `fifo_valid_o && fifo_grant_i`. Producer k transfers when `req_valid_i[k] && req_grant_o[k]`.
- **Producer rule:** once `req_valid_i[k]` is raised, the producer holds it and its data stable until granted.
- **Registered state:** round-robin pointer `rr_ptr` (IDX_W), `owner` (IDX_W), FSM state, burst counter `burst_cnt` (`$clog2(MAX_BURST+1)` bits).
- **FSM states:**
  - `IDLE`: no beat pending. Selection is combinational: the first valid producer searching from `rr_ptr` upward, with wrap-around modulo NUM_REQ.
  - `HOLD`: a beat was presented but not granted. The selection is frozen on `owner`, so `fifo_valid_o`/`fifo_data_o` stay stable until granted.
  - `BURST` (only with the macro): the owner keeps the selection after a transfer.
- **Transitions:**
  - `IDLE`, selected valid, grant=1 → transfer; `rr_ptr` ← sel+1 (wrap); stay `IDLE`, or enter `BURST` if the macro is set and MAX_BURST>1.
  - `IDLE`, selected valid, grant=0 → `HOLD`; `owner` ← sel.
  - `HOLD`, grant=1 → transfer; `rr_ptr` ← owner+1; → `IDLE` (or `BURST`).
  - `HOLD`, grant=0 → stay.
- **Output logic:**
  - `fifo_valid_o` = valid of the selected producer.
  - `fifo_data_o` = data of the selected producer; value is don't-care when not valid.
  - `req_grant_o[sel]` = `fifo_grant_i && fifo_valid_o`; all other grant bits are 0.
- **Combinational independence:** `fifo_valid_o` must not depend combinationally on `fifo_grant_i`.
- **Reset:** `reset` high at an edge forces state `IDLE`, `rr_ptr`=0, `owner`=0, `burst_cnt`=0. While `reset` is high, `fifo_valid_o`=0, `req_grant_o`=0 and `owner_o`=0. Reset mid-`HOLD`/`BURST` abandons the pending beat; no transfer is reported in that cycle.
- **No valid producers:** `fifo_valid_o`=0 and the state is unchanged, except `BURST`, which returns to `IDLE`.

## Timing
- Zero-cycle latency producer→FIFO; the path is combinational mux only.
- Grant path `fifo_grant_i`→`req_grant_o` is combinational (one AND per bit).
- A producer that loses arbitration sees `req_grant_o`=0 and retries each cycle.
- **Fairness:** with all NUM_REQ producers continuously valid and `fifo_grant_i`=1, beats rotate 0,1,…,NUM_REQ−1,0,… Without burst, each producer waits ≤ NUM_REQ−1 transfers.
- **FIFO full:** `fifo_grant_i`=0 for any number of cycles keeps `HOLD` on the same owner with data stable. Owner, data and `rr_ptr` do not change.
- `owner_o` equals the selection driving `fifo_data_o` in the same cycle.

## Configuration
- **`FIFO_ARB_BURST_EN` defined:** `BURST` state is compiled in.
  - After a transfer from owner k, selection stays on k while `req_valid_i[k]`=1, up to MAX_BURST total transfers.
  - `burst_cnt` counts transfers. When it reaches MAX_BURST, or k drops valid, the arbiter goes to `IDLE` with `rr_ptr`=k+1.
  - Grant=0 inside `BURST` holds selection and does not count.
  - Worst-case wait becomes (NUM_REQ−1)*MAX_BURST transfers.
- **Undefined:** no `BURST` state and no `burst_cnt`. Pure per-beat round-robin as above; MAX_BURST is ignored.

## Test plan
- **Reset:** assert `reset` 2 cycles with `req_valid_i`=4'b1111 → `fifo_valid_o`=0, `req_grant_o`=0, `owner_o`=0. First cycle after release: owner 0, data = producer 0's data.
- **Round-robin, burst off:** all 4 valid with data 8'h10,8'h21,8'h32,8'h43, `fifo_grant_i`=1 for 8 cycles → FIFO receives 10,21,32,43,10,21,32,43.
- **Backpressure hold:** producer 2 alone valid with 8'hA5, `fifo_grant_i`=0 for 5 cycles → `fifo_valid_o`=1, `fifo_data_o`=A5, `owner_o`=2 throughout. Producer 0 raising valid at cycle 3 does not steal the slot. Grant=1 → A5 transfers, then producer 0 is next.
- **Wrap-around:** `rr_ptr`=3 after a producer-2 transfer; producers 0 and 3 valid → 3 is granted first, then 0.
- **Burst (`FIFO_ARB_BURST_EN`, MAX_BURST=4):** producers 1 and 2 continuously valid, grant=1 → sequence 1,1,1,1,2,2,2,2,1… Producer 1 drops valid after 2 beats → switch to 2 immediately.
- **Reset mid-hold:** producer 1 in `HOLD`, `reset` pulse for 1 cycle → no grant that cycle. Next cycle arbitration restarts from producer 0.

Source files
------------

// File: rtl/fifo_push_arbiter_if.sv
// Purpose     : bundles the producer-side and FIFO-side push signals of fifo_push_arbiter.
// Latency     : n/a (wires only).
// Backpressure: fifo_grant_i from the FIFO is routed back to the selected producer's req_grant_o.
//
// Signals (direction as seen from the arbiter, i.e. the slave modport):
//   req_valid_i  [NUM_REQ]            per-producer valid
//   req_data_i   [NUM_REQ*DATA_WIDTH] producer k at [k*DATA_WIDTH +: DATA_WIDTH]
//   req_grant_o  [NUM_REQ]            per-producer grant, one-hot or zero
//   fifo_valid_o                      to FIFO push_valid_i
//   fifo_data_o  [DATA_WIDTH]         to FIFO push_data_i
//   fifo_grant_i                      from FIFO push_grant_o
//   owner_o      [IDX_W]              producer currently driving fifo_data_o
interface fifo_push_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]            req_grant_o;
  logic                          fifo_valid_o;
  logic [DATA_WIDTH-1:0]         fifo_data_o;
  logic                          fifo_grant_i;
  logic [IDX_W-1:0]              owner_o;

  // Arbiter side.
  modport slave (
    input  req_valid_i,
    input  req_data_i,
    input  fifo_grant_i,
    output req_grant_o,
    output fifo_valid_o,
    output fifo_data_o,
    output owner_o
  );

  // Producers + FIFO side (environment driving the arbiter).
  modport master (
    output req_valid_i,
    output req_data_i,
    output fifo_grant_i,
    input  req_grant_o,
    input  fifo_valid_o,
    input  fifo_data_o,
    input  owner_o
  );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Purpose     : round-robin arbiter sharing one FIFO push port among NUM_REQ producers.
// Latency     : zero cycles; producer valid/data reach the FIFO through a combinational mux.
// Backpressure: fifo_grant_i=0 freezes the selected producer (HOLD) until the FIFO accepts it.
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   reset  - synchronous, active-high; outputs forced idle while high
//   bus    - fifo_push_arbiter_if.slave (producer valid/data/grant, FIFO valid/data/grant, owner)
//
// Optional feature: define FIFO_ARB_BURST_EN to compile in the BURST state, letting an owner
// keep the port for up to MAX_BURST consecutive transfers while it stays valid. Without the
// macro the arbiter is pure per-beat round-robin and MAX_BURST has no effect.
module fifo_push_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fifo_push_arbiter_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || DATA_WIDTH < 1 || MAX_BURST < 1) begin : g_param_check
    $error("fifo_push_arbiter: NUM_REQ must be >= 2, DATA_WIDTH and MAX_BURST >= 1");
  end

`ifdef FIFO_ARB_BURST_EN
  typedef enum logic [1:0] {IDLE, HOLD, BURST} state_t;
  localparam int  CNT_W    = $clog2(MAX_BURST + 1);
  localparam bit  BURST_ON = (MAX_BURST > 1);
`else
  typedef enum logic [1:0] {IDLE, HOLD} state_t;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
`ifdef FIFO_ARB_BURST_EN
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
`endif

  logic [IDX_W-1:0] rr_sel;     // round-robin candidate searched from rr_ptr
  logic             rr_found;
  logic             use_owner;  // selection frozen on owner_q this cycle
  logic [IDX_W-1:0] sel;
  logic             sel_vld;
  logic             xfer;

  // (base + off) mod NUM_REQ for off in [0, NUM_REQ); works for non-power-of-two NUM_REQ.
  function automatic logic [IDX_W-1:0] rot(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[IDX_W-1:0];
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] x);
    return (x == IDX_W'(NUM_REQ - 1)) ? '0 : x + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Selection
  // ---------------------------------------------------------------------------
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rr_found && bus.req_valid_i[rot(rr_ptr_q, i)]) begin
        rr_found = 1'b1;
        rr_sel   = rot(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    use_owner = 1'b0;
    case (state_q)
      HOLD:    use_owner = 1'b1;
`ifdef FIFO_ARB_BURST_EN
      // Once the burst owner drops valid, fall back to round-robin in the same
      // cycle so the next producer is served without a bubble.
      BURST:   use_owner = bus.req_valid_i[owner_q];
`endif
      default: use_owner = 1'b0;
    endcase
  end

  assign sel     = use_owner ? owner_q : rr_sel;
  assign sel_vld = use_owner ? bus.req_valid_i[owner_q] : rr_found;

  // fifo_valid_o is a function of state and producer valids only, never of fifo_grant_i.
  assign bus.fifo_valid_o = !reset && sel_vld;
  assign bus.fifo_data_o  = bus.req_data_i[sel*DATA_WIDTH +: DATA_WIDTH];
  assign bus.owner_o      = reset ? '0 : sel;
  assign xfer             = bus.fifo_valid_o && bus.fifo_grant_i;

  always_comb begin
    bus.req_grant_o      = '0;
    bus.req_grant_o[sel] = xfer;
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
`ifdef FIFO_ARB_BURST_EN
    burst_cnt_d = burst_cnt_q;
`endif

    if (use_owner && state_q == HOLD) begin
      // Frozen beat: only a grant releases it. Owner never changes here.
      if (xfer) begin
        rr_ptr_d = next_idx(owner_q);
`ifdef FIFO_ARB_BURST_EN
        if (BURST_ON) begin
          state_d     = BURST;
          burst_cnt_d = CNT_W'(1);
        end else begin
          state_d     = IDLE;
        end
`else
        state_d  = IDLE;
`endif
      end
`ifdef FIFO_ARB_BURST_EN
    end else if (use_owner) begin
      // BURST with the owner still valid; a stalled beat does not count.
      if (xfer) begin
        rr_ptr_d = next_idx(owner_q);
        if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_cnt_q + 1'b1;
        end
      end
`endif
    end else begin
      // Arbitration: IDLE, or BURST whose owner has dropped valid.
      if (rr_found) begin
        owner_d = rr_sel;
        if (bus.fifo_grant_i) begin
          rr_ptr_d = next_idx(rr_sel);
`ifdef FIFO_ARB_BURST_EN
          if (BURST_ON) begin
            state_d     = BURST;
            burst_cnt_d = CNT_W'(1);
          end else begin
            state_d     = IDLE;
            burst_cnt_d = '0;
          end
`else
          state_d  = IDLE;
`endif
        end else begin
          state_d = HOLD;
`ifdef FIFO_ARB_BURST_EN
          burst_cnt_d = '0;
`endif
        end
      end else begin
        // Nothing valid: IDLE stays put, an abandoned BURST returns to IDLE.
        state_d = IDLE;
`ifdef FIFO_ARB_BURST_EN
        burst_cnt_d = '0;
`endif
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
`ifdef FIFO_ARB_BURST_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Purpose     : directed self-checking bench for fifo_push_arbiter (NUM_REQ=4, DATA_WIDTH=8).
// Latency     : checks are taken 3 time units after each rising edge, inputs change 1 unit after.
// Backpressure: fifo_grant_i is driven directly by the bench to model a full/non-full FIFO.
module tb_fifo_push_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;

  logic clk;
  logic reset;
  int   vecs        = 0;
  int   miscompares = 0;

  logic [7:0] pdat [4] = '{8'h10, 8'h21, 8'h32, 8'h43};

  fifo_push_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

  fifo_push_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .DATA_WIDTH(DATA_WIDTH),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: settle, compare, advance past the next rising edge.
  // Data and owner are compared only when chk_sel is set.
  task automatic cyc(input string tag, input logic ev, input logic [7:0] ed,
                     input logic [1:0] eo, input logic [3:0] eg, input bit chk_sel);
    #2;
    chk({tag, ".vld"}, 32'(bus.fifo_valid_o), 32'(ev));
    chk({tag, ".gnt"}, 32'(bus.req_grant_o), 32'(eg));
    if (chk_sel) begin
      chk({tag, ".own"}, 32'(bus.owner_o), 32'(eo));
      if (ev) chk({tag, ".dat"}, 32'(bus.fifo_data_o), 32'(ed));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load_data();
    for (int k = 0; k < 4; k++) bus.req_data_i[k*8 +: 8] = pdat[k];
  endtask

  initial begin
    // Reset with everyone valid and the FIFO granting: nothing may leak out.
    reset            = 1'b1;
    bus.req_valid_i  = 4'b1111;
    bus.fifo_grant_i = 1'b1;
    load_data();
    cyc("rst0", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b1);
    cyc("rst1", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b1);
    reset = 1'b0;

`ifndef FIFO_ARB_BURST_EN
    // Round-robin rotation 0,1,2,3,0,1,2,3; first beat is the post-reset check.
    for (int i = 0; i < 8; i++)
      cyc($sformatf("rr%0d", i), 1'b1, pdat[i%4], 2'(i%4), 4'(1 << (i%4)), 1'b1);

    // Backpressure: producer 2 held for 5 stalled cycles; producer 0 arrives mid-hold.
    bus.req_valid_i        = 4'b0100;
    bus.req_data_i[23:16]  = 8'hA5;
    bus.fifo_grant_i       = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) bus.req_valid_i[0] = 1'b1;
      cyc($sformatf("bp%0d", i), 1'b1, 8'hA5, 2'd2, 4'b0000, 1'b1);
    end
    bus.fifo_grant_i = 1'b1;
    cyc("bp_go", 1'b1, 8'hA5, 2'd2, 4'b0100, 1'b1);
    bus.req_valid_i = 4'b0001;
    cyc("bp_next", 1'b1, 8'h10, 2'd0, 4'b0001, 1'b1);

    // Wrap-around: transfer from 2 leaves rr_ptr at 3, so 3 beats 0.
    load_data();
    bus.req_valid_i = 4'b0100;
    cyc("wr_p2", 1'b1, 8'h32, 2'd2, 4'b0100, 1'b1);
    bus.req_valid_i = 4'b1001;
    cyc("wr_p3", 1'b1, 8'h43, 2'd3, 4'b1000, 1'b1);
    cyc("wr_p0", 1'b1, 8'h10, 2'd0, 4'b0001, 1'b1);

    // No producer valid: no beat and no grant even with the FIFO ready.
    bus.req_valid_i = 4'b0000;
    cyc("idle", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b0);

    // Reset while producer 1 is stalled in HOLD.
    bus.req_valid_i  = 4'b0010;
    bus.fifo_grant_i = 1'b0;
    cyc("mh_hold0", 1'b1, 8'h21, 2'd1, 4'b0000, 1'b1);
    cyc("mh_hold1", 1'b1, 8'h21, 2'd1, 4'b0000, 1'b1);
    reset            = 1'b1;
    bus.fifo_grant_i = 1'b1;
    cyc("mh_rst", 1'b0, 8'h00, 2'd0, 4'b0000, 1'b1);
    reset           = 1'b0;
    bus.req_valid_i = 4'b0011;
    cyc("mh_r0", 1'b1, 8'h10, 2'd0, 4'b0001, 1'b1);
    cyc("mh_r1", 1'b1, 8'h21, 2'd1, 4'b0010, 1'b1);
`else
    // Burst: producers 1 and 2 continuously valid, four beats each, then back to 1.
    begin
      int bs [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
      bus.req_valid_i = 4'b0110;
      for (int i = 0; i < 10; i++)
        cyc($sformatf("bu%0d", i), 1'b1, pdat[bs[i]], 2'(bs[i]), 4'(1 << bs[i]), 1'b1);
    end
    // Producer 1 drops after two beats of its burst: producer 2 takes over at once.
    bus.req_valid_i = 4'b0100;
    cyc("bu_drop", 1'b1, 8'h32, 2'd2, 4'b0100, 1'b1);
    // Stall inside the burst keeps the selection on producer 2.
    bus.fifo_grant_i = 1'b0;
    bus.req_valid_i  = 4'b0110;
    cyc("bu_stall", 1'b1, 8'h32, 2'd2, 4'b0000, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
